display_timing_cfg: RTL and testbench

Runtime-reconfigurable display timing generator: produces hsync, vsync, data enable, frame/line strobes and signed screen coordinates for any mode whose timings fit in CORDW bits. New timing sets are accepted through a valid/ready handshake and take effect only at a frame boundary, so a mode change never produces a torn frame. It sits between the pixel clock domain root and the pixel pipeline. A parameterised output delay aligns the sync signals with downstream pixel latency.

---
 rtl/display_timing_cfg.sv | 192 +++++++++++++++++++
 tb/tb_display_timing_cfg.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_timing_cfg.sv
// display_timing_cfg
//   Runtime-reconfigurable display timing generator. An active timing set
//   drives the x/y counters; a new set is accepted into a shadow register via
//   cfg_valid/cfg_ready and is swapped in only when the last pixel of a frame
//   is reached, so frames are never torn.
// Ports
//   clk_pix, rst_pix       pixel clock, synchronous active-high reset
//   cfg_valid/cfg_ready    timing-set handshake (ready = shadow register free)
//   cfg_h*/cfg_v*/cfg_*pol horizontal/vertical timing and sync polarities
//   cfg_applied            pulse with the first frame pulse of a newly applied set
//   hsync, vsync, de       syncs (with polarity) and data enable
//   frame, line            strobes at first blanking pixel of frame / line
//   sx, sy                 signed screen position, negative in blanking
//   frame_cnt              frames started since reset
module display_timing_cfg #(
  parameter int CORDW   = 16,
  parameter int OUT_LAT = 0,
  parameter int FCW     = 16,
  parameter int D_HRES  = 640,
  parameter int D_HFP   = 16,
  parameter int D_HSYNC = 96,
  parameter int D_HBP   = 48,
  parameter int D_VRES  = 480,
  parameter int D_VFP   = 10,
  parameter int D_VSYNC = 2,
  parameter int D_VBP   = 33,
  parameter int D_HPOL  = 0,
  parameter int D_VPOL  = 0
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CORDW-1:0]        cfg_hres,
  input  logic [CORDW-1:0]        cfg_hfp,
  input  logic [CORDW-1:0]        cfg_hsync,
  input  logic [CORDW-1:0]        cfg_hbp,
  input  logic [CORDW-1:0]        cfg_vres,
  input  logic [CORDW-1:0]        cfg_vfp,
  input  logic [CORDW-1:0]        cfg_vsync,
  input  logic [CORDW-1:0]        cfg_vbp,
  input  logic                    cfg_hpol,
  input  logic                    cfg_vpol,
  output logic                    cfg_applied,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    frame,
  output logic                    line,
  output logic signed [CORDW-1:0] sx,
  output logic signed [CORDW-1:0] sy,
  output logic [FCW-1:0]          frame_cnt
);

  typedef struct packed {
    logic [CORDW-1:0] hres, hfp, hsync, hbp;
    logic [CORDW-1:0] vres, vfp, vsync, vbp;
    logic             hpol, vpol;
  } raw_t;

  // Derived positions are stored as two's-complement bit patterns and
  // compared with $signed() where ordering matters.
  typedef struct packed {
    logic [CORDW-1:0] h_sta, hs_sta, hs_end, ha_end;
    logic [CORDW-1:0] v_sta, vs_sta, vs_end, va_end;
    logic             hpol, vpol;
  } tset_t;

  typedef struct packed {
    logic applied, frame, line, de, vsync, hsync;
  } flags_t;

  function automatic tset_t derive(input raw_t r);
    tset_t t;
    t.h_sta  = '0 - (r.hfp + r.hsync + r.hbp);
    t.hs_sta = t.h_sta + r.hfp;
    t.hs_end = t.hs_sta + r.hsync;
    t.ha_end = r.hres - CORDW'(1);
    t.v_sta  = '0 - (r.vfp + r.vsync + r.vbp);
    t.vs_sta = t.v_sta + r.vfp;
    t.vs_end = t.vs_sta + r.vsync;
    t.va_end = r.vres - CORDW'(1);
    t.hpol   = r.hpol;
    t.vpol   = r.vpol;
    return t;
  endfunction

  localparam raw_t DEF_RAW = '{
    hres: CORDW'(D_HRES), hfp: CORDW'(D_HFP), hsync: CORDW'(D_HSYNC), hbp: CORDW'(D_HBP),
    vres: CORDW'(D_VRES), vfp: CORDW'(D_VFP), vsync: CORDW'(D_VSYNC), vbp: CORDW'(D_VBP),
    hpol: (D_HPOL != 0), vpol: (D_VPOL != 0)
  };
  localparam tset_t  DEF_SET = derive(DEF_RAW);
  localparam flags_t FLG_RST = '{applied: 1'b0, frame: 1'b0, line: 1'b0, de: 1'b0,
                                 vsync: !DEF_RAW.vpol, hsync: !DEF_RAW.hpol};

  raw_t             cfg_raw, s_q, s_d;
  tset_t            a_q, a_d;
  logic             pend_q, pend_d;
  logic [CORDW-1:0] x_q, x_d, y_q, y_d;
  logic [CORDW-1:0] sx_q, sy_q;
  logic [FCW-1:0]   fcnt_q;
  logic             applied_q;
  logic             at_hend, last, apply;
  logic             hs_act, vs_act;
  flags_t           flg0;
  flags_t           pipe_q [OUT_LAT+1];

  assign cfg_raw = '{hres: cfg_hres, hfp: cfg_hfp, hsync: cfg_hsync, hbp: cfg_hbp,
                     vres: cfg_vres, vfp: cfg_vfp, vsync: cfg_vsync, vbp: cfg_vbp,
                     hpol: cfg_hpol, vpol: cfg_vpol};

  // Counter advance, handshake and frame-boundary swap. A handshake needs
  // pend_q low and a swap needs it high, so the two never coincide.
  always_comb begin
    at_hend = (x_q == a_q.ha_end);
    last    = at_hend && (y_q == a_q.va_end);
    apply   = last && pend_q;
    s_d     = s_q;
    pend_d  = pend_q;
    a_d     = a_q;
    x_d     = x_q + CORDW'(1);
    y_d     = y_q;
    if (cfg_valid && !pend_q) begin
      s_d    = cfg_raw;
      pend_d = 1'b1;
    end
    if (apply) begin
      a_d    = derive(s_q);
      pend_d = 1'b0;
      x_d    = a_d.h_sta;
      y_d    = a_d.v_sta;
    end else if (at_hend) begin
      x_d = a_q.h_sta;
      y_d = last ? a_q.v_sta : y_q + CORDW'(1);
    end
  end

  // First-stage output flags. applied_q is high exactly on the cycle the
  // counter sits at the origin of a freshly applied set, so it travels
  // alongside the frame strobe.
  always_comb begin
    hs_act       = ($signed(x_q) >= $signed(a_q.hs_sta)) && ($signed(x_q) < $signed(a_q.hs_end));
    vs_act       = ($signed(y_q) >= $signed(a_q.vs_sta)) && ($signed(y_q) < $signed(a_q.vs_end));
    flg0         = '0;
    flg0.applied = applied_q;
    flg0.line    = (x_q == a_q.h_sta);
    flg0.frame   = (x_q == a_q.h_sta) && (y_q == a_q.v_sta);
    flg0.de      = !x_q[CORDW-1] && !y_q[CORDW-1];
    flg0.hsync   = hs_act ~^ a_q.hpol;
    flg0.vsync   = vs_act ~^ a_q.vpol;
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      a_q       <= DEF_SET;
      s_q       <= DEF_RAW;
      pend_q    <= 1'b0;
      x_q       <= DEF_SET.h_sta;
      y_q       <= DEF_SET.v_sta;
      applied_q <= 1'b0;
      sx_q      <= DEF_SET.h_sta;
      sy_q      <= DEF_SET.v_sta;
      fcnt_q    <= '0;
      for (int unsigned i = 0; i <= OUT_LAT; i++) pipe_q[i] <= FLG_RST;
    end else begin
      a_q       <= a_d;
      s_q       <= s_d;
      pend_q    <= pend_d;
      x_q       <= x_d;
      y_q       <= y_d;
      applied_q <= apply;
      sx_q      <= x_q;
      sy_q      <= y_q;
      fcnt_q    <= fcnt_q + FCW'(flg0.frame);
      pipe_q[0] <= flg0;
      for (int unsigned i = 1; i <= OUT_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign cfg_ready   = !pend_q;
  assign sx          = sx_q;
  assign sy          = sy_q;
  assign frame_cnt   = fcnt_q;
  assign cfg_applied = pipe_q[OUT_LAT].applied;
  assign hsync       = pipe_q[OUT_LAT].hsync;
  assign vsync       = pipe_q[OUT_LAT].vsync;
  assign de          = pipe_q[OUT_LAT].de;
  assign frame       = pipe_q[OUT_LAT].frame;
  assign line        = pipe_q[OUT_LAT].line;

endmodule

// File: tb/tb_display_timing_cfg.sv
module tb_display_timing_cfg;
  localparam int CW = 16;
  localparam int FW = 16;
  // Scaled-down default mode: 80 x 31 total, 64 x 24 active.
  localparam int P_HRES = 64, P_HFP = 4, P_HSYNC = 8, P_HBP = 4;
  localparam int P_VRES = 24, P_VFP = 2, P_VSYNC = 2, P_VBP = 3;
  localparam int BOUND  = 6000;

  typedef struct packed {
    int hres, hfp, hsync, hbp, vres, vfp, vsync, vbp, hpol, vpol, applied;
  } cfg_t;

  typedef struct packed {
    int len, de_cnt, lines, hs_cnt, hs_bad, vs_cnt, applied_start, applied_other, fcnt, timeout;
  } frame_t;

  localparam cfg_t DEF_C = '{P_HRES, P_HFP, P_HSYNC, P_HBP, P_VRES, P_VFP, P_VSYNC, P_VBP, 0, 0, 0};
  localparam cfg_t SMALL = '{8, 1, 2, 1, 4, 1, 1, 1, 1, 0, 0};
  localparam cfg_t ALT   = '{10, 2, 3, 1, 3, 1, 2, 1, 0, 1, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0;
  logic [CW-1:0] c_hres = '0, c_hfp = '0, c_hsync = '0, c_hbp = '0;
  logic [CW-1:0] c_vres = '0, c_vfp = '0, c_vsync = '0, c_vbp = '0;
  logic c_hpol = 1'b0, c_vpol = 1'b0;

  logic cfg_ready, cfg_applied, hsync, vsync, de, frame, line;
  logic signed [CW-1:0] sx, sy;
  logic [FW-1:0] frame_cnt;

  logic cfg_ready3, cfg_applied3, hsync3, vsync3, de3, frame3, line3;
  logic signed [CW-1:0] sx3, sy3;
  logic [FW-1:0] frame_cnt3;

  int checks = 0;
  int errors = 0;
  int exp_fcnt = 0;
  cfg_t exp_q[$];

  always #5 clk = ~clk;

  display_timing_cfg #(
    .CORDW(CW), .OUT_LAT(0), .FCW(FW),
    .D_HRES(P_HRES), .D_HFP(P_HFP), .D_HSYNC(P_HSYNC), .D_HBP(P_HBP),
    .D_VRES(P_VRES), .D_VFP(P_VFP), .D_VSYNC(P_VSYNC), .D_VBP(P_VBP),
    .D_HPOL(0), .D_VPOL(0)
  ) dut (
    .clk_pix(clk), .rst_pix(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_hres(c_hres), .cfg_hfp(c_hfp), .cfg_hsync(c_hsync), .cfg_hbp(c_hbp),
    .cfg_vres(c_vres), .cfg_vfp(c_vfp), .cfg_vsync(c_vsync), .cfg_vbp(c_vbp),
    .cfg_hpol(c_hpol), .cfg_vpol(c_vpol), .cfg_applied(cfg_applied),
    .hsync(hsync), .vsync(vsync), .de(de), .frame(frame), .line(line),
    .sx(sx), .sy(sy), .frame_cnt(frame_cnt)
  );

  display_timing_cfg #(
    .CORDW(CW), .OUT_LAT(3), .FCW(FW),
    .D_HRES(P_HRES), .D_HFP(P_HFP), .D_HSYNC(P_HSYNC), .D_HBP(P_HBP),
    .D_VRES(P_VRES), .D_VFP(P_VFP), .D_VSYNC(P_VSYNC), .D_VBP(P_VBP),
    .D_HPOL(0), .D_VPOL(0)
  ) dut3 (
    .clk_pix(clk), .rst_pix(rst), .cfg_valid(1'b0), .cfg_ready(cfg_ready3),
    .cfg_hres('0), .cfg_hfp('0), .cfg_hsync('0), .cfg_hbp('0),
    .cfg_vres('0), .cfg_vfp('0), .cfg_vsync('0), .cfg_vbp('0),
    .cfg_hpol(1'b0), .cfg_vpol(1'b0), .cfg_applied(cfg_applied3),
    .hsync(hsync3), .vsync(vsync3), .de(de3), .frame(frame3), .line(line3),
    .sx(sx3), .sy(sy3), .frame_cnt(frame_cnt3)
  );

  function automatic frame_t expect_of(input cfg_t c, input int fc);
    frame_t e;
    int htot, vtot;
    htot = c.hres + c.hfp + c.hsync + c.hbp;
    vtot = c.vres + c.vfp + c.vsync + c.vbp;
    e = '0;
    e.len = htot * vtot;
    e.de_cnt = c.hres * c.vres;
    e.lines = vtot;
    e.hs_cnt = c.hsync * vtot;
    e.vs_cnt = c.vsync * htot;
    e.applied_start = c.applied;
    e.fcnt = fc;
    return e;
  endfunction

  task automatic drive_cfg(input cfg_t c);
    c_hres = CW'(c.hres); c_hfp = CW'(c.hfp); c_hsync = CW'(c.hsync); c_hbp = CW'(c.hbp);
    c_vres = CW'(c.vres); c_vfp = CW'(c.vfp); c_vsync = CW'(c.vsync); c_vbp = CW'(c.vbp);
    c_hpol = c.hpol[0]; c_vpol = c.vpol[0];
  endtask

  // Measures one frame of the OUT_LAT=0 instance, from a frame pulse up to
  // (not including) the next one. Leaves time at the next pulse's sample point.
  task automatic measure_frame(input cfg_t c, output frame_t m);
    int n;
    m = '0;
    n = 0;
    while (frame !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (frame !== 1'b1) begin
      m.timeout = 1;
    end else begin
      m.fcnt = int'(frame_cnt);
      m.applied_start = int'(cfg_applied);
      do begin
        m.len++;
        if (m.len > 1 && cfg_applied) m.applied_other++;
        if (de) m.de_cnt++;
        if (line) m.lines++;
        if (hsync == c.hpol[0]) begin
          m.hs_cnt++;
          if (int'(sx) < -(c.hsync + c.hbp) || int'(sx) > -c.hbp - 1) m.hs_bad++;
        end
        if (vsync == c.vpol[0]) m.vs_cnt++;
        @(negedge clk);
      end while (frame !== 1'b1 && m.len < BOUND);
      if (frame !== 1'b1) m.timeout = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({hsync, vsync, de, frame, line, cfg_ready, cfg_applied} !== 7'b1100010) begin
      errors++;
      $display("FAIL reset_flags got %b exp 1100010", {hsync, vsync, de, frame, line, cfg_ready, cfg_applied});
    end
    checks++;
    if (frame_cnt !== '0 || sx !== -16 || sy !== -7) begin
      errors++;
      $display("FAIL reset_pos got fcnt=%0d sx=%0d sy=%0d exp 0 -16 -7", frame_cnt, sx, sy);
    end
    checks++;
    if ({hsync3, vsync3, de3, frame3, line3} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_lat3 got %b exp 11000", {hsync3, vsync3, de3, frame3, line3});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (frame !== 1'b1 || frame_cnt !== FW'(1) || sx !== -16 || sy !== -7) begin
      errors++;
      $display("FAIL first_frame got frame=%b fcnt=%0d sx=%0d sy=%0d exp 1 1 -16 -7", frame, frame_cnt, sx, sy);
    end
    exp_fcnt = 0;
  endtask

  task automatic test_default_frame();
    cfg_t c;
    frame_t m, e;
    exp_q.push_back(DEF_C);
    exp_q.push_back(DEF_C);
    repeat (2) begin
      c = exp_q.pop_front();
      measure_frame(c, m);
      exp_fcnt++;
      e = expect_of(c, exp_fcnt);
      checks++;
      if (m !== e) begin
        errors++;
        $display("FAIL default_frame got %p exp %p", m, e);
      end
    end
  endtask

  task automatic test_midframe_cfg();
    cfg_t c, s;
    frame_t m, e;
    s = SMALL;
    s.applied = 1;
    exp_q.push_back(DEF_C);
    exp_q.push_back(s);
    fork
      begin
        c = exp_q.pop_front();
        measure_frame(c, m);
        exp_fcnt++;
        e = expect_of(c, exp_fcnt);
        checks++;
        if (m !== e) begin
          errors++;
          $display("FAIL midframe_old got %p exp %p", m, e);
        end
      end
      begin
        repeat (100) @(negedge clk);
        drive_cfg(SMALL);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
          errors++;
          $display("FAIL midframe_ready got %b exp 0", cfg_ready);
        end
      end
    join
    c = exp_q.pop_front();
    measure_frame(c, m);
    exp_fcnt++;
    e = expect_of(c, exp_fcnt);
    checks++;
    if (m !== e) begin
      errors++;
      $display("FAIL midframe_new got %p exp %p", m, e);
    end
  endtask

  task automatic test_back_to_back();
    cfg_t c, a, b;
    frame_t m, e;
    bit found;
    a = ALT;
    a.applied = 1;
    b = SMALL;
    b.applied = 1;
    exp_q.push_back(SMALL);
    exp_q.push_back(a);
    exp_q.push_back(b);
    fork
      begin
        repeat (3) begin
          c = exp_q.pop_front();
          measure_frame(c, m);
          exp_fcnt++;
          e = expect_of(c, exp_fcnt);
          checks++;
          if (m !== e) begin
            errors++;
            $display("FAIL b2b_frame got %p exp %p", m, e);
          end
        end
      end
      begin
        repeat (10) @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready_free got %b exp 1", cfg_ready);
        end
        drive_cfg(ALT);
        cfg_valid = 1'b1;
        @(negedge clk);
        drive_cfg(SMALL);
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
          if (cfg_ready) found = 1;
          else @(negedge clk);
        end
        checks++;
        if (!found || sx !== 7 || sy !== 3) begin
          errors++;
          $display("FAIL b2b_ready_return got found=%0d sx=%0d sy=%0d exp 1 7 3", found, sx, sy);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_second_accept got %b exp 0", cfg_ready);
        end
      end
    join
  endtask

  task automatic test_last_pixel_handshake();
    cfg_t c, a;
    frame_t m, e;
    bit found;
    a = ALT;
    a.applied = 1;
    exp_q.push_back(SMALL);
    exp_q.push_back(SMALL);
    exp_q.push_back(a);
    fork
      begin
        repeat (3) begin
          c = exp_q.pop_front();
          measure_frame(c, m);
          exp_fcnt++;
          e = expect_of(c, exp_fcnt);
          checks++;
          if (m !== e) begin
            errors++;
            $display("FAIL lastpix_frame got %p exp %p", m, e);
          end
        end
      end
      begin
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
          @(negedge clk);
          if (sx == 6 && sy == 3) found = 1;
        end
        drive_cfg(ALT);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++;
        if (!found || sx !== 7 || sy !== 3 || cfg_ready !== 1'b0) begin
          errors++;
          $display("FAIL lastpix_accept got found=%0d sx=%0d sy=%0d ready=%b exp 1 7 3 0", found, sx, sy, cfg_ready);
        end
      end
    join
  endtask

  task automatic test_reset_midframe();
    cfg_t c;
    frame_t m, e;
    int n;
    drive_cfg(SMALL);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    n = 0;
    while (de !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (de !== 1'b1 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_setup got de=%b ready=%b exp 1 0", de, cfg_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({hsync, vsync, de, frame, line, cfg_ready, cfg_applied} !== 7'b1100010 || frame_cnt !== '0) begin
      errors++;
      $display("FAIL rstmid_state got %b fcnt=%0d exp 1100010 0",
               {hsync, vsync, de, frame, line, cfg_ready, cfg_applied}, frame_cnt);
    end
    rst = 1'b0;
    exp_fcnt = 0;
    exp_q.push_back(DEF_C);
    exp_q.push_back(DEF_C);
    repeat (2) begin
      c = exp_q.pop_front();
      measure_frame(c, m);
      exp_fcnt++;
      e = expect_of(c, exp_fcnt);
      checks++;
      if (m !== e) begin
        errors++;
        $display("FAIL rstmid_frame got %p exp %p", m, e);
      end
    end
  endtask

  task automatic test_out_lat();
    int rise_q[$];
    int n, rises, want;
    logic prev;
    n = 0;
    while (frame3 !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    rises = 0;
    prev = de3;
    for (int t = 0; t < 80 * 31; t++) begin
      if (sx3 == 0 && sy3 >= 0) rise_q.push_back(t + 3);
      if (de3 && !prev) begin
        rises++;
        want = (rise_q.size() > 0) ? rise_q.pop_front() : -1;
        checks++;
        if (t !== want) begin
          errors++;
          $display("FAIL lat3_de_rise got cycle %0d exp %0d", t, want);
        end
      end
      prev = de3;
      @(negedge clk);
    end
    checks++;
    if (rises !== P_VRES) begin
      errors++;
      $display("FAIL lat3_rise_count got %0d exp %0d", rises, P_VRES);
    end
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_default_frame();
    test_midframe_cfg();
    test_back_to_back();
    test_last_pixel_handshake();
    test_reset_midframe();
    test_out_lat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
